// File: rtl/line_clear_pkg.sv
// Shared types and constants for the playfield line-clear sequencer.
// The LINE_CLEAR_SCORE_EN build option uses SCORE_TABLE to add scoring.
package line_clear_pkg;

    localparam int DEF_ROWS = 20;
    localparam int DEF_COLS = 10;

    typedef logic [1:0] cell_t;
    typedef cell_t [DEF_COLS-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        EV   = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } lc_state_e;

    // Points per clear, indexed by min(lines, 4), before the level multiplier.
    localparam logic [4:0][10:0] SCORE_TABLE = {11'd1200, 11'd300, 11'd100, 11'd40, 11'd0};

endpackage

// File: rtl/row_full_detect.sv
// Combinational check that every 2-bit cell of a row is non-empty.
// The preview renderer reuses this block.
module row_full_detect #(
    parameter int COLS = 10
) (
    input  logic [2*COLS-1:0] row,
    output logic              full
);

    always_comb begin
        full = 1'b1;
        for (int i = 0; i < COLS; i++) begin
            if (row[2*i +: 2] == 2'b00) full = 1'b0;
        end
    end

endmodule

// File: rtl/line_clear_sequencer.sv
// Bottom-up line-clear scan and compaction over the playfield RAM, then zero-fill of the top rows.
// Build option LINE_CLEAR_SCORE_EN adds the level input and a saturating score output.
module line_clear_sequencer
    import line_clear_pkg::*;
#(
    parameter  int ROWS = DEF_ROWS,
    parameter  int COLS = DEF_COLS,
    localparam int AW   = $clog2(ROWS),
    localparam int CW   = $clog2(ROWS + 1)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     lines_cleared,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_rd_addr,
    input  logic [2*COLS-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [AW-1:0]     mem_wr_addr,
    output logic [2*COLS-1:0] mem_wdata
`ifdef LINE_CLEAR_SCORE_EN
    ,
    input  logic [3:0]        level,
    output logic [19:0]       score
`endif
);

    // RAM handshake: one read per RD cycle, data consumed in the following EV cycle;
    // there is no back-pressure, strobes are single-cycle and always accepted.
    lc_state_e         state, state_next;
    logic [AW-1:0]     rd_row, wr_row;
    logic [CW-1:0]     cnt;
    logic              row_full;
    logic [CW-1:0]     cnt_next;

    row_full_detect #(.COLS(COLS)) u_row_full (
        .row  (mem_rdata),
        .full (row_full)
    );

    assign cnt_next      = (state == EV && row_full) ? cnt + CW'(1) : cnt;
    assign lines_cleared = cnt;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RD;
            RD:   state_next = EV;
            EV: begin
                if (rd_row == '0) state_next = (cnt_next != '0) ? FILL : DONE;
                else              state_next = RD;
            end
            FILL: if (wr_row == '0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Scan pointers and full-row count.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rd_row <= AW'(ROWS - 1);
            wr_row <= AW'(ROWS - 1);
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_row <= AW'(ROWS - 1);
                        wr_row <= AW'(ROWS - 1);
                        cnt    <= '0;
                    end
                end
                EV: begin
                    cnt <= cnt_next;
                    if (!row_full)     wr_row <= wr_row - AW'(1);
                    if (rd_row != '0) rd_row <= rd_row - AW'(1);
                end
                FILL: begin
                    if (wr_row != '0) wr_row <= wr_row - AW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wdata   = '0;
        case (state)
            RD: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = rd_row;
            end
            EV: begin
                // A kept row already at its destination needs no rewrite.
                if (!row_full && wr_row != rd_row) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = wr_row;
                    mem_wdata   = mem_rdata;
                end
            end
            FILL: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = wr_row;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [2:0]  tbl_idx;
    logic [15:0] score_inc;
    logic [20:0] score_sum;

    always_comb begin
        tbl_idx   = (cnt >= CW'(4)) ? 3'd4 : 3'(cnt);
        score_inc = 16'(SCORE_TABLE[tbl_idx]) * (16'(level) + 16'd1);
        score_sum = {1'b0, score} + 21'(score_inc);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) score <= '0;
        else if (state == DONE) score <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
    end
`endif

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Scoreboard bench for line_clear_sequencer with a behavioural 1-cycle-latency playfield RAM.
// Build with +define+LINE_CLEAR_SCORE_EN to also exercise the score output.
module tb_line_clear_sequencer;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int W    = 2 * COLS;
  localparam int AW   = 5;
  localparam int CW   = 5;

  logic          clk = 1'b0;
  logic          Reset;
  logic          start;
  logic          busy, done;
  logic [CW-1:0] lines_cleared;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [W-1:0]  mem_rdata = '0;
  logic [W-1:0]  mem_wdata;
`ifdef LINE_CLEAR_SCORE_EN
  logic [3:0]    level;
  logic [19:0]   score;
  logic [19:0]   exp_score;
`endif

  logic [W-1:0]  ram [ROWS];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [W-1:0]  tb_wd = '0;
  logic [W-1:0]  stim [ROWS];
  logic [W-1:0]  exp_q [$];

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  line_clear_sequencer dut (
    .clk           (clk),
    .Reset         (Reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rdata     (mem_rdata),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wdata     (mem_wdata)
`ifdef LINE_CLEAR_SCORE_EN
    ,
    .level         (level),
    .score         (score)
`endif
  );

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_rd_addr];
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wdata;
    if (tb_we) ram[tb_wa] <= tb_wd;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic bit is_full(input logic [W-1:0] r);
    for (int c = 0; c < COLS; c++) if (r[2*c +: 2] == 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] full_row();
    logic [W-1:0] r;
    for (int c = 0; c < COLS; c++) r[2*c +: 2] = 2'($urandom_range(1, 3));
    return r;
  endfunction

  function automatic logic [W-1:0] part_row();
    logic [W-1:0] r;
    int k;
    r = W'($urandom);
    k = $urandom_range(0, COLS - 1);
    r[2*k +: 2] = 2'b00;
    return r;
  endfunction

`ifdef LINE_CLEAR_SCORE_EN
  function automatic int pts(input int n);
    case (n)
      0: return 0;
      1: return 40;
      2: return 100;
      3: return 300;
      default: return 1200;
    endcase
  endfunction
`endif

  task automatic load_board();
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clk);
      tb_we = 1'b1;
      tb_wa = AW'(r);
      tb_wd = stim[r];
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Expected outcome of a clear on stim[]: count, latency, write strobes, final board.
  task automatic push_expected();
    logic [W-1:0] fin [ROWS];
    int n = 0;
    int wr = ROWS - 1;
    int writes = 0;
    for (int r = 0; r < ROWS; r++) fin[r] = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (is_full(stim[r])) n++;
      else begin
        fin[wr] = stim[r];
        if (wr != r) writes++;
        wr--;
      end
    end
    writes += n;
    exp_q.push_back(W'(n));
    exp_q.push_back(W'(2 * ROWS + n + 1));
    exp_q.push_back(W'(writes));
    for (int r = 0; r < ROWS; r++) exp_q.push_back(fin[r]);
`ifdef LINE_CLEAR_SCORE_EN
    if (exp_score + pts(n) * (level + 1) > 20'hFFFFF) exp_score = 20'hFFFFF;
    else exp_score = exp_score + 20'(pts(n) * (level + 1));
    exp_q.push_back(exp_score);
`endif
  endtask

  task automatic run_case(input string name, input bit restart_mid);
    int cyc = 0;
    int wrs = 0;
    int busy_low = 0;
    bit got_done = 0;
    logic [W-1:0] e;
    load_board();
    push_expected();
    @(negedge clk);
    start = 1'b1;
    while (!got_done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = restart_mid && (cyc == 5);
      if (mem_wr_en) wrs++;
      if (mem_rd_en && mem_wr_en && mem_rd_addr == mem_wr_addr) overlap++;
      if (!busy) busy_low++;
      if (done) got_done = 1;
    end
    check({name, "_timeout"}, 32'(got_done), 32'd1);
    e = exp_q.pop_front(); check({name, "_lines"}, 32'(lines_cleared), 32'(e));
    e = exp_q.pop_front(); check({name, "_latency"}, 32'(cyc), 32'(e));
    e = exp_q.pop_front(); check({name, "_writes"}, 32'(wrs), 32'(e));
    for (int r = 0; r < ROWS; r++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_row%0d", name, r), 32'(ram[r]), 32'(e));
    end
    check({name, "_busy"}, 32'(busy_low), 32'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    check({name, "_lines_held"}, 32'(lines_cleared), 32'(exp_q.size() >= 0 ? lines_cleared : '0));
`ifdef LINE_CLEAR_SCORE_EN
    e = exp_q.pop_front(); check({name, "_score"}, 32'(score), 32'(e));
`endif
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_lines"}, 32'(lines_cleared), 32'd0);
    check({name, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({name, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    check({name, "_addrs"}, {22'd0, mem_rd_addr, mem_wr_addr}, 32'd0);
    check({name, "_wdata"}, 32'(mem_wdata), 32'd0);
`ifdef LINE_CLEAR_SCORE_EN
    check({name, "_score"}, 32'(score), 32'd0);
`endif
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
    level = 4'd0;
    exp_score = '0;
`endif
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    Reset = 1'b0;

    // Empty board: nothing moves, nothing written.
    for (int r = 0; r < ROWS; r++) stim[r] = '0;
    run_case("empty", 1'b0);

    // Row 19 full; a second start mid-run must be ignored.
    for (int r = 0; r < ROWS; r++) stim[r] = part_row();
    stim[19] = full_row();
    stim[18] = 20'hA5A5A & 20'hFFFFC | 20'h00000;
`ifdef LINE_CLEAR_SCORE_EN
    level = 4'($urandom_range(0, 15));
`endif
    run_case("one_line", 1'b1);

    // Rows 19 and 17 full with distinct survivors between them.
    for (int r = 0; r < ROWS; r++) stim[r] = part_row();
    stim[19] = full_row();
    stim[18] = 20'h0BBBB;
    stim[17] = full_row();
    stim[16] = 20'hC0C0C;
    run_case("two_lines", 1'b0);

    // Whole board full.
    for (int r = 0; r < ROWS; r++) stim[r] = full_row();
    run_case("all_full", 1'b0);

    // Four bottom rows full at level 2.
    for (int r = 0; r < ROWS; r++) stim[r] = part_row();
    for (int r = 16; r < ROWS; r++) stim[r] = full_row();
`ifdef LINE_CLEAR_SCORE_EN
    level = 4'd2;
`endif
    run_case("tetris", 1'b0);

    // A row with a single empty cell must survive intact.
    for (int r = 0; r < ROWS; r++) stim[r] = part_row();
    stim[19] = full_row();
    stim[10] = 20'hFFFFF;
    stim[10][2*($urandom_range(0, COLS - 1)) +: 2] = 2'b00;
    run_case("one_hole", 1'b0);

    // Abort in FILL: all-full board reaches FILL at cycle 41.
    for (int r = 0; r < ROWS; r++) stim[r] = full_row();
    load_board();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 43; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_in_fill_wr", 32'(mem_wr_en), 32'd1);
    Reset = 1'b1;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    Reset = 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
    exp_score = '0;
    level = 4'd5;
`endif

    // Fresh run after the abort.
    for (int r = 0; r < ROWS; r++) stim[r] = part_row();
    stim[19] = full_row();
    stim[5]  = full_row();
    stim[0]  = full_row();
    run_case("after_abort", 1'b0);

    check("rd_wr_same_addr", 32'(overlap), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
